f11_wbs: RTL and testbench



---
 rtl/f11_wbs_pkg.sv | 45 ++++
 rtl/f11_wbs_if.sv | 29 ++
 rtl/f11_wbs_ram.sv | 27 ++
 rtl/f11_wbs.sv | 230 +++++++++++++++++++++++
 tb/tb_f11_wbs.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/f11_wbs_pkg.sv
// Shared types and constants for the F-11 Wishbone slave responder:
// FSM encodings, I/O register word offsets, vector mask and lane helpers.
package f11_wbs_pkg;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_WAIT = 2'd1,
    MS_ACK  = 2'd2,
    MS_HOLD = 2'd3
  } ms_state_t;

  typedef enum logic [1:0] {
    IS_IDLE = 2'd0,
    IS_ACK  = 2'd1,
    IS_HOLD = 2'd2
  } is_state_t;

  // Word offsets within the I/O bank, i.e. adr[3:1]
  localparam logic [2:0] IO_IVR4 = 3'd0;
  localparam logic [2:0] IO_IVR5 = 3'd1;
  localparam logic [2:0] IO_IVR6 = 3'd2;
  localparam logic [2:0] IO_IVR7 = 3'd3;
  localparam logic [2:0] IO_FDR  = 3'd4;

  localparam logic [15:0] VEC_MASK = 16'o000774;

  // Index (0..3 = level 4..7) of the highest pending request
  function automatic logic [1:0] top_level(input logic [3:0] req);
    logic [1:0] lvl;
    casez (req)
      4'b1???: lvl = 2'd3;
      4'b01??: lvl = 2'd2;
      4'b001?: lvl = 2'd1;
      default: lvl = 2'd0;
    endcase
    return lvl;
  endfunction

  function automatic logic [15:0] lane_merge(input logic [15:0] old,
                                             input logic [15:0] wr,
                                             input logic [1:0]  sel);
    return {sel[1] ? wr[15:8] : old[15:8], sel[0] ? wr[7:0] : old[7:0]};
  endfunction

endpackage

// File: rtl/f11_wbs_if.sv
// Master-bus and interrupt/fast-input bus signals between the F-11 master
// and its slave responder.
interface f11_wbs_if;
  logic        wbs_ios_i;
  logic [21:0] wbs_adr_i;
  logic [15:0] wbs_dat_i;
  logic [15:0] wbs_dat_o;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [1:0]  wbs_sel_i;
  logic        wbs_ack_o;
  logic        wbi_stb_i;
  logic        wbi_una_i;
  logic [15:0] wbi_dat_o;
  logic        wbi_ack_o;

  modport slave (
    input  wbs_ios_i, wbs_adr_i, wbs_dat_i, wbs_cyc_i, wbs_stb_i, wbs_we_i,
           wbs_sel_i, wbi_stb_i, wbi_una_i,
    output wbs_dat_o, wbs_ack_o, wbi_dat_o, wbi_ack_o
  );

  modport master (
    output wbs_ios_i, wbs_adr_i, wbs_dat_i, wbs_cyc_i, wbs_stb_i, wbs_we_i,
           wbs_sel_i, wbi_stb_i, wbi_una_i,
    input  wbs_dat_o, wbs_ack_o, wbi_dat_o, wbi_ack_o
  );
endinterface

// File: rtl/f11_wbs_ram.sv
// Byte-lane-writable synchronous single-port RAM, 2^AW x 16, one-cycle read.
// Contents are deliberately not reset.
module f11_wbs_ram #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic [1:0]    sel,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [0:(1 << AW) - 1];

  // Lane writes and registered read of the addressed word
  always_ff @(posedge clk) begin
    if (we && sel[0]) begin
      mem[addr][7:0] <= wdata[7:0];
    end
    if (we && sel[1]) begin
      mem[addr][15:8] <= wdata[15:8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/f11_wbs.sv
// F-11 Wishbone slave responder: RAM and I/O-register bank on the master bus,
// vector acknowledge / fast-data read on the interrupt bus, registered IRQ lines.
module f11_wbs
  import f11_wbs_pkg::*;
#(
  parameter int          MEM_AW   = 13,
  parameter int          WAIT_CYC = 0,
  parameter logic [21:0] IO_BASE  = 22'o17777700,
  parameter logic [15:0] FDR_RST  = 16'o173000
) (
  input  logic       vm_clk_p,
  input  logic       vm_rst_n,
  f11_wbs_if.slave   bus,
  input  logic [3:0] irq_i,
  output logic [3:0] irq_ack_o,
  output logic [3:0] vm_virq
);

  ms_state_t          ms_state_r, ms_next_s;
  is_state_t          is_state_r, is_next_s;
  logic [3:0]         cnt_r;
  logic [MEM_AW-1:0]  adr_r;
  logic               io_r, we_r;
  logic [2:0]         reg_r;
  logic [1:0]         sel_r;
  logic [15:0]        wdat_r;
  logic [15:0]        ivr_r [0:3];
  logic [15:0]        fdr_r;
  logic [15:0]        ram_rdata_s, io_rd_s;
  logic [MEM_AW-1:0]  ram_addr_s;
  logic               mem_hit_s, io_hit_s, commit_s, wbi_fire_s;
  logic [1:0]         lvl_s;
  logic               wbs_ack_r, wbi_ack_r;
  logic [15:0]        wbs_dat_r, wbi_dat_r;
  logic [3:0]         irq_ack_r, virq_r;

  assign mem_hit_s = ~bus.wbs_ios_i && ((bus.wbs_adr_i >> (MEM_AW + 1)) == 22'd0);
  assign io_hit_s  = bus.wbs_ios_i && (bus.wbs_adr_i[21:4] == IO_BASE[21:4])
                     && (bus.wbs_adr_i[3:1] <= IO_FDR);
  assign lvl_s     = top_level(virq_r);

  // Master FSM next state; commit_s marks the WAIT->ACK edge
  always_comb begin
    ms_next_s = ms_state_r;
    commit_s  = 1'b0;
    case (ms_state_r)
      MS_IDLE: begin
        if (bus.wbs_cyc_i && bus.wbs_stb_i && (mem_hit_s || io_hit_s)) begin
          ms_next_s = MS_WAIT;
        end else begin
          ms_next_s = MS_IDLE;
        end
      end
      MS_WAIT: begin
        if (!(bus.wbs_cyc_i && bus.wbs_stb_i)) begin
          ms_next_s = MS_IDLE;
        end else if (cnt_r == 4'd0) begin
          ms_next_s = MS_ACK;
          commit_s  = 1'b1;
        end else begin
          ms_next_s = MS_WAIT;
        end
      end
      MS_ACK:  ms_next_s = MS_HOLD;
      MS_HOLD: begin
        if (!bus.wbs_stb_i) begin
          ms_next_s = MS_IDLE;
        end else begin
          ms_next_s = MS_HOLD;
        end
      end
      default: ms_next_s = MS_IDLE;
    endcase
  end

  // Master FSM state and wait-state counter
  always_ff @(posedge vm_clk_p) begin
    if (!vm_rst_n) begin
      ms_state_r <= MS_IDLE;
      cnt_r      <= 4'd0;
    end else begin
      ms_state_r <= ms_next_s;
      if (ms_state_r == MS_IDLE) begin
        cnt_r <= 4'(WAIT_CYC);
      end else if (ms_state_r == MS_WAIT && cnt_r != 4'd0) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Request capture; only the value latched on the IDLE->WAIT edge matters
  always_ff @(posedge vm_clk_p) begin
    if (!vm_rst_n) begin
      adr_r  <= {MEM_AW{1'b0}};
      io_r   <= 1'b0;
      reg_r  <= 3'd0;
      we_r   <= 1'b0;
      sel_r  <= 2'b00;
      wdat_r <= 16'h0000;
    end else if (ms_state_r == MS_IDLE) begin
      adr_r  <= bus.wbs_adr_i[MEM_AW:1];
      io_r   <= bus.wbs_ios_i;
      reg_r  <= bus.wbs_adr_i[3:1];
      we_r   <= bus.wbs_we_i;
      sel_r  <= bus.wbs_sel_i;
      wdat_r <= bus.wbs_dat_i;
    end else begin
      adr_r  <= adr_r;
      io_r   <= io_r;
      reg_r  <= reg_r;
      we_r   <= we_r;
      sel_r  <= sel_r;
      wdat_r <= wdat_r;
    end
  end

  // Address straight from the bus while idle so zero-wait reads have data in time
  assign ram_addr_s = (ms_state_r == MS_IDLE) ? bus.wbs_adr_i[MEM_AW:1] : adr_r;

  f11_wbs_ram #(.AW(MEM_AW)) u_ram (
    .clk   (vm_clk_p),
    .we    (commit_s && we_r && !io_r),
    .sel   (sel_r),
    .addr  (ram_addr_s),
    .wdata (wdat_r),
    .rdata (ram_rdata_s)
  );

  // I/O register read mux
  always_comb begin
    io_rd_s = 16'h0000;
    case (reg_r)
      IO_IVR4, IO_IVR5, IO_IVR6, IO_IVR7: io_rd_s = ivr_r[reg_r[1:0]];
      IO_FDR:  io_rd_s = fdr_r;
      default: io_rd_s = 16'h0000;
    endcase
  end

  // I/O register writes
  always_ff @(posedge vm_clk_p) begin
    if (!vm_rst_n) begin
      for (int i = 0; i < 4; i++) begin
        ivr_r[i] <= 16'h0000;
      end
      fdr_r <= FDR_RST;
    end else if (commit_s && we_r && io_r) begin
      case (reg_r)
        IO_IVR4, IO_IVR5, IO_IVR6, IO_IVR7:
          ivr_r[reg_r[1:0]] <= lane_merge(ivr_r[reg_r[1:0]], wdat_r, sel_r);
        IO_FDR:  fdr_r <= lane_merge(fdr_r, wdat_r, sel_r);
        default: fdr_r <= fdr_r;
      endcase
    end
  end

  // Master-bus ack and read data; read data holds until the next read ack
  always_ff @(posedge vm_clk_p) begin
    if (!vm_rst_n) begin
      wbs_ack_r <= 1'b0;
      wbs_dat_r <= 16'h0000;
    end else begin
      wbs_ack_r <= commit_s;
      if (commit_s && !we_r) begin
        wbs_dat_r <= io_r ? io_rd_s : ram_rdata_s;
      end else begin
        wbs_dat_r <= wbs_dat_r;
      end
    end
  end

  // Interrupt-bus FSM next state; wbi_fire_s marks an acknowledged strobe
  always_comb begin
    is_next_s  = is_state_r;
    wbi_fire_s = 1'b0;
    case (is_state_r)
      IS_IDLE: begin
        if (bus.wbi_stb_i && (bus.wbi_una_i || virq_r != 4'b0000)) begin
          is_next_s  = IS_ACK;
          wbi_fire_s = 1'b1;
        end else begin
          is_next_s = IS_IDLE;
        end
      end
      IS_ACK:  is_next_s = IS_HOLD;
      IS_HOLD: begin
        if (!bus.wbi_stb_i) begin
          is_next_s = IS_IDLE;
        end else begin
          is_next_s = IS_HOLD;
        end
      end
      default: is_next_s = IS_IDLE;
    endcase
  end

  // Interrupt-bus state, outputs and IRQ line registering
  always_ff @(posedge vm_clk_p) begin
    if (!vm_rst_n) begin
      is_state_r <= IS_IDLE;
      wbi_ack_r  <= 1'b0;
      wbi_dat_r  <= 16'h0000;
      irq_ack_r  <= 4'b0000;
      virq_r     <= 4'b0000;
    end else begin
      is_state_r <= is_next_s;
      virq_r     <= irq_i;
      wbi_ack_r  <= wbi_fire_s;
      if (wbi_fire_s && bus.wbi_una_i) begin
        wbi_dat_r <= fdr_r;
        irq_ack_r <= 4'b0000;
      end else if (wbi_fire_s) begin
        wbi_dat_r <= ivr_r[lvl_s] & VEC_MASK;
        irq_ack_r <= 4'b0001 << lvl_s;
      end else begin
        wbi_dat_r <= wbi_dat_r;
        irq_ack_r <= 4'b0000;
      end
    end
  end

  assign bus.wbs_ack_o = wbs_ack_r;
  assign bus.wbs_dat_o = wbs_dat_r;
  assign bus.wbi_ack_o = wbi_ack_r;
  assign bus.wbi_dat_o = wbi_dat_r;
  assign irq_ack_o     = irq_ack_r;
  assign vm_virq       = virq_r;

endmodule

// File: tb/tb_f11_wbs.sv
// Self-checking bench for f11_wbs: two instances (2 and 5 wait states) share
// the same bus stimulus; results are checked against a behavioural model.
`timescale 1ns/1ps
module tb_f11_wbs;

  localparam logic [21:0] IO_BASE = 22'o17777700;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, rst5_n, use5;
  logic        ios, cyc, stb, we, wbi_stb, wbi_una;
  logic [21:0] adr;
  logic [15:0] wdat;
  logic [1:0]  sel;
  logic [3:0]  irq, irq_ack0, virq0, irq_ack5, virq5;

  f11_wbs_if bus0 ();
  f11_wbs_if bus5 ();

  assign bus0.wbs_ios_i = ios;  assign bus5.wbs_ios_i = ios;
  assign bus0.wbs_adr_i = adr;  assign bus5.wbs_adr_i = adr;
  assign bus0.wbs_dat_i = wdat; assign bus5.wbs_dat_i = wdat;
  assign bus0.wbs_cyc_i = cyc;  assign bus5.wbs_cyc_i = cyc;
  assign bus0.wbs_stb_i = stb;  assign bus5.wbs_stb_i = stb;
  assign bus0.wbs_we_i  = we;   assign bus5.wbs_we_i  = we;
  assign bus0.wbs_sel_i = sel;  assign bus5.wbs_sel_i = sel;
  assign bus0.wbi_stb_i = wbi_stb; assign bus5.wbi_stb_i = wbi_stb;
  assign bus0.wbi_una_i = wbi_una; assign bus5.wbi_una_i = wbi_una;

  f11_wbs #(.MEM_AW(13), .WAIT_CYC(2)) u_dut (
    .vm_clk_p (clk), .vm_rst_n (rst0_n), .bus (bus0),
    .irq_i (irq), .irq_ack_o (irq_ack0), .vm_virq (virq0)
  );

  f11_wbs #(.MEM_AW(13), .WAIT_CYC(5)) u_dut5 (
    .vm_clk_p (clk), .vm_rst_n (rst5_n), .bus (bus5),
    .irq_i (irq), .irq_ack_o (irq_ack5), .vm_virq (virq5)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] mem_m [int];
  logic [15:0] io_m [0:4];
  logic [21:0] pool [0:7];

  // One master-bus strobe held for 'hold' clocks; reports acks seen on the selected DUT
  task automatic bus_xfer(input logic i_ios, input logic [21:0] i_adr, input logic i_we,
                          input logic [15:0] i_dat, input logic [1:0] i_sel, input int hold,
                          output int n_ack, output int lat, output logic [15:0] rd);
    logic a;
    logic [15:0] d;
    @(negedge clk);
    ios = i_ios; adr = i_adr; we = i_we; wdat = i_dat; sel = i_sel; cyc = 1'b1; stb = 1'b1;
    n_ack = 0; lat = -1; rd = 16'h0000;
    for (int k = 1; k <= hold; k++) begin
      @(posedge clk); #1;
      a = use5 ? bus5.wbs_ack_o : bus0.wbs_ack_o;
      d = use5 ? bus5.wbs_dat_o : bus0.wbs_dat_o;
      if (a) begin
        n_ack++;
        if (lat < 0) begin lat = k; rd = d; end
      end
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); @(posedge clk);
  endtask

  // One interrupt-bus strobe on the 2-wait DUT
  task automatic int_xfer(input logic una, output int n_ack, output int lat,
                          output logic [15:0] d, output logic [3:0] ia, output int n_ia);
    @(negedge clk);
    wbi_stb = 1'b1; wbi_una = una;
    n_ack = 0; lat = -1; d = 16'h0000; ia = 4'b0000; n_ia = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (irq_ack0 != 4'b0000) n_ia++;
      if (bus0.wbi_ack_o) begin
        n_ack++;
        if (lat < 0) begin lat = k; d = bus0.wbi_dat_o; ia = irq_ack0; end
      end
    end
    @(negedge clk);
    wbi_stb = 1'b0;
    @(posedge clk); @(posedge clk);
  endtask

  task automatic set_irq(input logic [3:0] v);
    @(negedge clk);
    irq = v;
    @(posedge clk); @(posedge clk);
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] s);
    logic [15:0] r;
    r = old;
    if (s[0]) r[7:0] = d[7:0];
    if (s[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  task automatic test_reset;
    int n, l, ni;
    logic [15:0] d;
    logic [3:0] ia;
    ios = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 22'd0; wdat = 16'h0000; sel = 2'b00;
    wbi_stb = 1'b0; wbi_una = 1'b0; irq = 4'b1111; use5 = 1'b0;
    rst0_n = 1'b0; rst5_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    vectors++; if (bus0.wbs_ack_o !== 1'b0) begin miscompares++; $display("FAIL rst_wbs_ack got %b want 0", bus0.wbs_ack_o); end
    vectors++; if (bus0.wbi_ack_o !== 1'b0) begin miscompares++; $display("FAIL rst_wbi_ack got %b want 0", bus0.wbi_ack_o); end
    vectors++; if (bus0.wbs_dat_o !== 16'h0000) begin miscompares++; $display("FAIL rst_wbs_dat got %o want 0", bus0.wbs_dat_o); end
    vectors++; if (bus0.wbi_dat_o !== 16'h0000) begin miscompares++; $display("FAIL rst_wbi_dat got %o want 0", bus0.wbi_dat_o); end
    vectors++; if (irq_ack0 !== 4'b0000) begin miscompares++; $display("FAIL rst_irq_ack got %b want 0000", irq_ack0); end
    vectors++; if (virq0 !== 4'b0000 || virq5 !== 4'b0000) begin miscompares++; $display("FAIL rst_virq got %b/%b want 0000", virq0, virq5); end
    @(negedge clk);
    rst0_n = 1'b1; rst5_n = 1'b1; irq = 4'b0000;
    for (int i = 0; i < 4; i++) io_m[i] = 16'h0000;
    io_m[4] = 16'o173000;
    int_xfer(1'b1, n, l, d, ia, ni);
    vectors++; if (n !== 1 || l !== 1) begin miscompares++; $display("FAIL rst_fdr_ack got n=%0d lat=%0d want n=1 lat=1", n, l); end
    vectors++; if (d !== 16'o173000) begin miscompares++; $display("FAIL rst_fdr_val got %o want 173000", d); end
  endtask

  task automatic test_mem_rw;
    int n, l;
    logic [15:0] rd;
    bus_xfer(1'b0, 22'o001000, 1'b1, 16'o123456, 2'b11, 10, n, l, rd);
    vectors++; if (n !== 1 || l !== 4) begin miscompares++; $display("FAIL mem_wr_ack got n=%0d lat=%0d want n=1 lat=4", n, l); end
    bus_xfer(1'b0, 22'o001000, 1'b0, 16'h0000, 2'b11, 10, n, l, rd);
    vectors++; if (n !== 1 || l !== 4) begin miscompares++; $display("FAIL mem_rd_ack got n=%0d lat=%0d want n=1 lat=4", n, l); end
    vectors++; if (rd !== 16'o123456) begin miscompares++; $display("FAIL mem_rd_val got %o want 123456", rd); end
    mem_m[22'o001000 >> 1] = 16'o123456;
  endtask

  task automatic test_byte_lanes;
    int n, l;
    logic [15:0] rd;
    bus_xfer(1'b0, 22'o002000, 1'b1, 16'o000377, 2'b11, 10, n, l, rd);
    bus_xfer(1'b0, 22'o002000, 1'b1, 16'o177400, 2'b10, 10, n, l, rd);
    bus_xfer(1'b0, 22'o002000, 1'b0, 16'h0000, 2'b00, 10, n, l, rd);
    vectors++; if (rd !== 16'o177777) begin miscompares++; $display("FAIL lane_hi got %o want 177777", rd); end
    bus_xfer(1'b0, 22'o002000, 1'b1, 16'o000000, 2'b00, 10, n, l, rd);
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL sel00_ack got %0d want 1", n); end
    bus_xfer(1'b0, 22'o002001, 1'b0, 16'h0000, 2'b01, 10, n, l, rd);
    vectors++; if (rd !== 16'o177777) begin miscompares++; $display("FAIL sel00_keep got %o want 177777", rd); end
  endtask

  task automatic test_no_hit;
    int n, l;
    logic [15:0] rd;
    bus_xfer(1'b0, 22'd16384, 1'b0, 16'h0000, 2'b11, 100, n, l, rd);
    vectors++; if (n !== 0) begin miscompares++; $display("FAIL miss_mem got %0d acks want 0", n); end
    bus_xfer(1'b1, IO_BASE + 22'o12, 1'b0, 16'h0000, 2'b11, 100, n, l, rd);
    vectors++; if (n !== 0) begin miscompares++; $display("FAIL miss_io got %0d acks want 0", n); end
  endtask

  task automatic test_vector;
    int n, l, ni;
    logic [15:0] rd;
    logic [3:0] ia;
    bus_xfer(1'b1, IO_BASE + 22'o6, 1'b1, 16'o000310, 2'b11, 10, n, l, rd);
    io_m[3] = 16'o000310;
    set_irq(4'b1010);
    int_xfer(1'b0, n, l, rd, ia, ni);
    vectors++; if (n !== 1 || l !== 1) begin miscompares++; $display("FAIL vec_ack got n=%0d lat=%0d want n=1 lat=1", n, l); end
    vectors++; if (rd !== 16'o000310) begin miscompares++; $display("FAIL vec_val got %o want 000310", rd); end
    vectors++; if (ia !== 4'b1000 || ni !== 1) begin miscompares++; $display("FAIL vec_irqack got %b x%0d want 1000 x1", ia, ni); end
    set_irq(4'b0000);
    int_xfer(1'b0, n, l, rd, ia, ni);
    vectors++; if (n !== 0 || ni !== 0) begin miscompares++; $display("FAIL vec_none got ack=%0d irqack=%0d want 0/0", n, ni); end
  endtask

  task automatic test_random;
    int n, l, ni, op, k;
    logic [15:0] rd, d, ev, exp_v;
    logic [3:0] ia, r, exp_ia;
    logic [21:0] a;
    logic [1:0] s;
    logic hit;
    for (int i = 0; i < 8; i++) begin
      pool[i] = 22'(($urandom_range(0, 8191)) * 2);
      d = 16'($urandom);
      bus_xfer(1'b0, pool[i], 1'b1, d, 2'b11, 10, n, l, rd);
      mem_m[int'(pool[i] >> 1)] = d;
    end
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 4);
      d = 16'($urandom);
      s = 2'($urandom_range(0, 3));
      case (op)
        0, 1: begin
          a = pool[$urandom_range(0, 7)] | 22'($urandom_range(0, 1));
          bus_xfer(1'b0, a, (op == 0), d, s, 10, n, l, rd);
          vectors++; if (n !== 1 || l !== 4) begin miscompares++; $display("FAIL rnd_mem_ack it=%0d got n=%0d lat=%0d want 1/4", it, n, l); end
          if (op == 0) mem_m[int'(a >> 1)] = merge(mem_m[int'(a >> 1)], d, s);
          else begin
            vectors++; if (rd !== mem_m[int'(a >> 1)]) begin miscompares++; $display("FAIL rnd_mem_rd adr=%o got %o want %o", a, rd, mem_m[int'(a >> 1)]); end
          end
        end
        2, 3: begin
          k = $urandom_range(0, 4);
          bus_xfer(1'b1, IO_BASE + 22'(2 * k), (op == 2), d, s, 10, n, l, rd);
          vectors++; if (n !== 1 || l !== 4) begin miscompares++; $display("FAIL rnd_io_ack it=%0d got n=%0d lat=%0d want 1/4", it, n, l); end
          if (op == 2) io_m[k] = merge(io_m[k], d, s);
          else begin
            vectors++; if (rd !== io_m[k]) begin miscompares++; $display("FAIL rnd_io_rd reg=%0d got %o want %o", k, rd, io_m[k]); end
          end
        end
        default: begin
          r = 4'($urandom_range(0, 15));
          set_irq(r);
          if ($urandom_range(0, 1) == 1) begin
            int_xfer(1'b1, n, l, rd, ia, ni);
            vectors++; if (n !== 1 || rd !== io_m[4] || ni !== 0) begin miscompares++; $display("FAIL rnd_fdr got n=%0d d=%o ia=%0d want 1 %o 0", n, rd, ni, io_m[4]); end
          end else begin
            hit = 1'b0; exp_v = 16'h0000; exp_ia = 4'b0000;
            for (int lv = 7; lv >= 4; lv--) begin
              if (!hit && r[lv - 4]) begin
                hit = 1'b1; ev = io_m[lv - 4]; exp_v = ev & 16'o000774; exp_ia = 4'(1 << (lv - 4));
              end
            end
            int_xfer(1'b0, n, l, rd, ia, ni);
            vectors++;
            if (n !== int'(hit) || (hit && (rd !== exp_v || ia !== exp_ia || ni !== 1))) begin
              miscompares++;
              $display("FAIL rnd_vec irq=%b got n=%0d d=%o ia=%b want n=%0d d=%o ia=%b", r, n, rd, ia, hit, exp_v, exp_ia);
            end
          end
        end
      endcase
    end
    set_irq(4'b0000);
  endtask

  task automatic test_concurrent;
    int nw, ni, lw, li;
    logic [21:0] a;
    a = pool[0];
    @(negedge clk);
    ios = 1'b0; adr = a; we = 1'b0; sel = 2'b11; cyc = 1'b1; stb = 1'b1;
    wbi_stb = 1'b1; wbi_una = 1'b1;
    nw = 0; ni = 0; lw = -1; li = -1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (bus0.wbs_ack_o) begin nw++; if (lw < 0) lw = k; end
      if (bus0.wbi_ack_o) begin ni++; if (li < 0) li = k; end
      if (k == 4 && bus0.wbs_dat_o !== mem_m[int'(a >> 1)]) begin
        miscompares++; $display("FAIL conc_rd got %o want %o", bus0.wbs_dat_o, mem_m[int'(a >> 1)]);
      end
    end
    vectors++;
    vectors++; if (nw !== 1 || lw !== 4 || ni !== 1 || li !== 1) begin miscompares++; $display("FAIL conc_ack got wbs %0d@%0d wbi %0d@%0d want 1@4 1@1", nw, lw, ni, li); end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; wbi_stb = 1'b0;
    @(posedge clk); @(posedge clk);
  endtask

  task automatic test_reset_abort;
    int n, l, nack;
    logic [15:0] rd;
    use5 = 1'b1;
    bus_xfer(1'b0, 22'o000100, 1'b1, 16'o000111, 2'b11, 10, n, l, rd);
    vectors++; if (n !== 1 || l !== 7) begin miscompares++; $display("FAIL w5_ack got n=%0d lat=%0d want 1/7", n, l); end
    @(negedge clk);
    ios = 1'b0; adr = 22'o000100; we = 1'b1; wdat = 16'o177777; sel = 2'b11; cyc = 1'b1; stb = 1'b1;
    nack = 0;
    repeat (3) begin @(posedge clk); #1; if (bus5.wbs_ack_o) nack++; end
    @(negedge clk);
    rst5_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (bus5.wbs_ack_o) nack++; end
    @(negedge clk);
    rst5_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; if (bus5.wbs_ack_o) nack++; end
    vectors++; if (nack !== 0) begin miscompares++; $display("FAIL abort_ack got %0d acks want 0", nack); end
    bus_xfer(1'b0, 22'o000100, 1'b0, 16'h0000, 2'b11, 10, n, l, rd);
    vectors++; if (n !== 1 || l !== 7) begin miscompares++; $display("FAIL abort_next_ack got n=%0d lat=%0d want 1/7", n, l); end
    vectors++; if (rd !== 16'o000111) begin miscompares++; $display("FAIL abort_keep got %o want 000111", rd); end
    use5 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mem_rw();
    test_byte_lanes();
    test_no_hit();
    test_vector();
    test_random();
    test_concurrent();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
